// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between core (port 0) and DMA (port 1).
// Latency: accept in N, memory driven in N+1, read data or error response in N+2.
// Backpressure: only the losing requester of a tie sees ready=0; one accept per cycle.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ready,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_valid,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ready,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  // Highest legal word-aligned byte address.
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_DEPTH * 4 - 4);

  // Port granted most recently; 1 after reset so port 0 wins the first tie.
  logic                  last_grant;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_bad;

  logic                  s1_vld;
  logic                  s1_id;
  logic                  s1_we;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_wdata;
  logic                  s1_bad;

  logic                  s2_vld;
  logic                  s2_id;
  logic                  s2_is_read;
  logic                  s2_bad;
  logic [DATA_WIDTH-1:0] p0_rdata_q;
  logic [DATA_WIDTH-1:0] p1_rdata_q;

  // Grant: a lone requester always wins; on a tie the port not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (p0_valid && (!p1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (p1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept   = grant0 | grant1;
  assign p0_ready = grant0;
  assign p1_ready = grant1;

  // Select the winning request and classify it before registering.
  always_comb begin
    req_we    = grant1 ? p1_we    : p0_we;
    req_addr  = grant1 ? p1_addr  : p0_addr;
    req_wdata = grant1 ? p1_wdata : p0_wdata;
    req_bad   = (req_addr[1:0] != 2'b00) || (req_addr > MAX_ADDR);
  end

  // Last-grant pointer moves only when a request is actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end

  // Stage 1: the accepted request; addr/wdata hold while idle so the memory bus stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_id    <= 1'b0;
      s1_we    <= 1'b0;
      s1_addr  <= '0;
      s1_wdata <= '0;
      s1_bad   <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_id    <= grant1;
        s1_we    <= req_we;
        s1_addr  <= req_addr;
        s1_wdata <= req_wdata;
        s1_bad   <= req_bad;
      end
    end
  end

  // Bad accesses still present their address but never assert the write enable.
  assign mem_addr = s1_addr;
  assign mem_wd   = s1_wdata;
  assign mem_we   = s1_vld & s1_we & ~s1_bad;

  // Stage 2: response tag plus per-port read data, captured only for good reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld     <= 1'b0;
      s2_id      <= 1'b0;
      s2_is_read <= 1'b0;
      s2_bad     <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      s2_vld     <= s1_vld;
      s2_id      <= s1_id;
      s2_is_read <= ~s1_we;
      s2_bad     <= s1_bad;
      if (s1_vld && !s1_we && !s1_bad) begin
        if (s1_id) begin
          p1_rdata_q <= mem_rd;
        end else begin
          p0_rdata_q <= mem_rd;
        end
      end
    end
  end

  // Responses are steered to the originating port; good writes stay silent.
  assign p0_rvalid = s2_vld & s2_is_read & ~s2_bad & ~s2_id;
  assign p1_rvalid = s2_vld & s2_is_read & ~s2_bad &  s2_id;
  assign p0_err    = s2_vld & s2_bad & ~s2_id;
  assign p1_err    = s2_vld & s2_bad &  s2_id;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Memory word i is preloaded with 32'hC0DE_0000 + i unless overridden below.
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p0_we, p0_ready, p0_rvalid, p0_err;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_valid, p1_we, p1_ready, p1_rvalid, p1_err;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic [DW-1:0] mem [0:DEPTH-1];

  int vectors     = 0;
  int miscompares = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, synchronous write; preload and writes share one process.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[4] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (mem_we && mem_addr < 32'(DEPTH * 4)) mem[mem_addr[11:2]] = mem_wd;
    end
  end

  always_comb begin
    mem_rd = '0;
    if (mem_addr < 32'(DEPTH * 4)) mem_rd = mem[mem_addr[11:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    next_cycle();
    rst = 1'b1; p0_valid = 1'b1; p0_addr = 32'h10; p1_valid = 1'b1;
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready} !== 2'b00) begin miscompares++; $display("FAIL rst_ready: got %b want 00", {p0_ready, p1_ready}); end
    next_cycle();
    rst = 1'b0; idle_inputs();
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we} !== 7'b0) begin miscompares++; $display("FAIL rst_ctrl: got %b want 0000000", {p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we}); end
    vectors++; if ({mem_addr, mem_wd} !== 64'h0) begin miscompares++; $display("FAIL rst_mem_bus: got %h want 0", {mem_addr, mem_wd}); end
    vectors++; if ({p0_rdata, p1_rdata} !== 64'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", {p0_rdata, p1_rdata}); end
  endtask

  task automatic test_single_read;
    next_cycle();
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready} !== 2'b10) begin miscompares++; $display("FAIL rd_ready: got %b want 10", {p0_ready, p1_ready}); end
    next_cycle();
    p0_valid = 1'b0;
    mid_cycle();
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL rd_mem_addr: got %h want 00000010", mem_addr); end
    vectors++; if ({p0_rvalid, mem_we} !== 2'b00) begin miscompares++; $display("FAIL rd_early: got %b want 00", {p0_rvalid, mem_we}); end
    next_cycle();
    mid_cycle();
    vectors++; if (p0_rvalid !== 1'b1) begin miscompares++; $display("FAIL rd_rvalid: got %b want 1", p0_rvalid); end
    vectors++; if (p0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_rdata: got %h want deadbeef", p0_rdata); end
    vectors++; if ({p1_rvalid, p1_err, p0_err, p1_ready, p1_rdata} !== 36'h0) begin miscompares++; $display("FAIL rd_p1_quiet: got %h want 0", {p1_rvalid, p1_err, p0_err, p1_ready, p1_rdata}); end
    next_cycle();
    mid_cycle();
    vectors++; if (p0_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_pulse: got %b want 0", p0_rvalid); end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      p0_valid = (i < 6); p0_we = 1'b0; p0_addr = 32'h40 + 32'(4 * ((i + 1) / 2));
      p1_valid = (i < 6); p1_we = 1'b0; p1_addr = 32'h80 + 32'(4 * (i / 2));
      mid_cycle();
      begin
        logic [1:0]    exp_rdy;
        logic [1:0]    exp_rv;
        logic [DW-1:0] exp_dat;
        logic [DW-1:0] got_dat;
        exp_rdy = (i >= 6) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
        vectors++; if ({p0_ready, p1_ready} !== exp_rdy) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {p0_ready, p1_ready}, exp_rdy); end
        if (i >= 2) begin
          exp_rv  = ((i - 2) % 2 == 0) ? 2'b10 : 2'b01;
          exp_dat = ((i - 2) % 2 == 0) ? 32'hC0DE_0010 + 32'((i - 2) / 2) : 32'hC0DE_0020 + 32'((i - 2) / 2);
          got_dat = ((i - 2) % 2 == 0) ? p0_rdata : p1_rdata;
          vectors++; if ({p0_rvalid, p1_rvalid} !== exp_rv) begin miscompares++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, {p0_rvalid, p1_rvalid}, exp_rv); end
          vectors++; if (got_dat !== exp_dat) begin miscompares++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, got_dat, exp_dat); end
        end
      end
    end
  endtask

  task automatic test_read_after_write;
    next_cycle();
    p1_valid = 1'b0; p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h1234_5678;
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready} !== 2'b10) begin miscompares++; $display("FAIL raw_wr_ready: got %b want 10", {p0_ready, p1_ready}); end
    next_cycle();
    p0_we = 1'b0; p0_wdata = '0;
    mid_cycle();
    vectors++; if (p0_ready !== 1'b1) begin miscompares++; $display("FAIL raw_rd_ready: got %b want 1", p0_ready); end
    vectors++; if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h20, 32'h1234_5678}) begin miscompares++; $display("FAIL raw_mem_write: got %h want 1_00000020_12345678", {mem_we, mem_addr, mem_wd}); end
    next_cycle();
    p0_valid = 1'b0;
    mid_cycle();
    vectors++; if ({mem_we, p0_rvalid, p0_err} !== 3'b000) begin miscompares++; $display("FAIL raw_write_silent: got %b want 000", {mem_we, p0_rvalid, p0_err}); end
    next_cycle();
    mid_cycle();
    vectors++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h1234_5678}) begin miscompares++; $display("FAIL raw_rdata: got %h want 1_12345678", {p0_rvalid, p0_rdata}); end
    next_cycle();
    mid_cycle();
    vectors++; if ({p0_rvalid, mem_we} !== 2'b00) begin miscompares++; $display("FAIL raw_done: got %b want 00", {p0_rvalid, mem_we}); end
  endtask

  task automatic test_errors;
    next_cycle();
    p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h22; p1_wdata = 32'hCAFE_F00D;
    mid_cycle();
    vectors++; if (p1_ready !== 1'b1) begin miscompares++; $display("FAIL err_wr_ready: got %b want 1", p1_ready); end
    next_cycle();
    p1_we = 1'b0; p1_addr = 32'h1000; p1_wdata = '0;
    mid_cycle();
    vectors++; if ({p1_ready, mem_we} !== 2'b10) begin miscompares++; $display("FAIL err_misaligned_we: got %b want 10", {p1_ready, mem_we}); end
    next_cycle();
    p1_addr = 32'hFFC;
    mid_cycle();
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL err_range_we: got %b want 0", mem_we); end
    vectors++; if ({p1_err, p1_rvalid, p0_err} !== 3'b100) begin miscompares++; $display("FAIL err_misaligned_resp: got %b want 100", {p1_err, p1_rvalid, p0_err}); end
    next_cycle();
    p1_valid = 1'b0;
    mid_cycle();
    vectors++; if ({p1_err, p1_rvalid, p0_err} !== 3'b100) begin miscompares++; $display("FAIL err_range_resp: got %b want 100", {p1_err, p1_rvalid, p0_err}); end
    vectors++; if (p1_rdata !== 32'hC0DE_0022) begin miscompares++; $display("FAIL err_rdata_hold: got %h want c0de0022", p1_rdata); end
    next_cycle();
    mid_cycle();
    vectors++; if ({p1_err, p1_rvalid, p1_rdata} !== {2'b01, 32'hC0DE_03FF}) begin miscompares++; $display("FAIL err_top_word: got %h want 1_c0de03ff", {p1_err, p1_rvalid, p1_rdata}); end
    vectors++; if (mem[8] !== 32'h1234_5678) begin miscompares++; $display("FAIL err_mem_untouched: got %h want 12345678", mem[8]); end
    next_cycle();
    mid_cycle();
    vectors++; if ({p1_err, p1_rvalid} !== 2'b00) begin miscompares++; $display("FAIL err_done: got %b want 00", {p1_err, p1_rvalid}); end
  endtask

  task automatic test_reset_in_flight;
    next_cycle();
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready} !== 2'b10) begin miscompares++; $display("FAIL rif_accept: got %b want 10", {p0_ready, p1_ready}); end
    next_cycle();
    p0_valid = 1'b0; rst = 1'b1; p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h0;
    mid_cycle();
    vectors++; if (p1_ready !== 1'b0) begin miscompares++; $display("FAIL rif_ready_in_rst: got %b want 0", p1_ready); end
    next_cycle();
    rst = 1'b0; idle_inputs();
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we} !== 7'b0) begin miscompares++; $display("FAIL rif_ctrl: got %b want 0000000", {p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we}); end
    vectors++; if ({mem_addr, mem_wd, p0_rdata, p1_rdata} !== 128'h0) begin miscompares++; $display("FAIL rif_data: got %h want 0", {mem_addr, mem_wd, p0_rdata, p1_rdata}); end
    next_cycle();
    mid_cycle();
    vectors++; if ({p0_rvalid, p0_err} !== 2'b00) begin miscompares++; $display("FAIL rif_dropped: got %b want 00", {p0_rvalid, p0_err}); end
    next_cycle();
    p0_valid = 1'b1; p0_addr = 32'h0; p1_valid = 1'b1; p1_addr = 32'h4;
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready} !== 2'b10) begin miscompares++; $display("FAIL rif_first_tie: got %b want 10", {p0_ready, p1_ready}); end
    next_cycle();
    p0_valid = 1'b0;
    mid_cycle();
    vectors++; if ({p0_ready, p1_ready} !== 2'b01) begin miscompares++; $display("FAIL rif_p1_next: got %b want 01", {p0_ready, p1_ready}); end
    next_cycle();
    p1_valid = 1'b0;
    mid_cycle();
    vectors++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hC0DE_0000}) begin miscompares++; $display("FAIL rif_p0_resp: got %h want 1_c0de0000", {p0_rvalid, p0_rdata}); end
    next_cycle();
    mid_cycle();
    vectors++; if ({p1_rvalid, p1_rdata} !== {1'b1, 32'hC0DE_0001}) begin miscompares++; $display("FAIL rif_p1_resp: got %h want 1_c0de0001", {p1_rvalid, p1_rdata}); end
  endtask

  task automatic test_p1_stream;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      p1_valid = (i <= 5); p1_we = 1'b0; p1_addr = 32'h100 + 32'(4 * ((i < 4) ? i : 4));
      p0_valid = (i == 4); p0_we = 1'b0; p0_addr = 32'h200;
      mid_cycle();
      begin
        logic [1:0]    exp_rdy;
        logic [1:0]    exp_rv;
        logic [DW-1:0] exp_dat;
        logic [DW-1:0] got_dat;
        exp_rdy = (i > 5) ? 2'b00 : ((i == 4) ? 2'b10 : 2'b01);
        vectors++; if ({p0_ready, p1_ready} !== exp_rdy) begin miscompares++; $display("FAIL stream_grant[%0d]: got %b want %b", i, {p0_ready, p1_ready}, exp_rdy); end
        if (i >= 2) begin
          exp_rv  = (i - 2 == 4) ? 2'b10 : 2'b01;
          exp_dat = (i - 2 == 4) ? 32'hC0DE_0080 : 32'hC0DE_0040 + 32'((i - 2 < 4) ? i - 2 : 4);
          got_dat = (i - 2 == 4) ? p0_rdata : p1_rdata;
          vectors++; if ({p0_rvalid, p1_rvalid} !== exp_rv) begin miscompares++; $display("FAIL stream_rvalid[%0d]: got %b want %b", i, {p0_rvalid, p1_rvalid}, exp_rv); end
          vectors++; if (got_dat !== exp_dat) begin miscompares++; $display("FAIL stream_rdata[%0d]: got %h want %h", i, got_dat, exp_dat); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_after_write();
    test_errors();
    test_reset_in_flight();
    test_p1_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
